// File: rtl/window_avg_out_if.sv
// rtl/window_avg_out_if.sv - stream/statistics bundle between the summer, the averager and its consumer
interface window_avg_out_if #(
    parameter int WIDTH = 8,
    parameter int SW    = 11
);
    logic [SW-1:0]    i_sum;
    logic             i_valid;
    logic [WIDTH-1:0] o_avg;
    logic             o_valid;
    logic             i_ready;
    logic             o_overflow;
    logic [WIDTH-1:0] o_min;
    logic [WIDTH-1:0] o_max;
    logic             o_frame_done;

    modport slave (
        input  i_sum, i_valid, i_ready,
        output o_avg, o_valid, o_overflow, o_min, o_max, o_frame_done
    );

    modport master (
        output i_sum, i_valid, i_ready,
        input  o_avg, o_valid, o_overflow, o_min, o_max, o_frame_done
    );
endinterface

// File: rtl/window_avg_out.sv
// rtl/window_avg_out.sv - rounded moving average with warm-up discard, 2-entry output queue and frame min/max
module window_avg_out #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int SW    = WIDTH + $clog2(DEPTH),
    parameter int FRAME = 16
) (
    input  logic             clk,
    input  logic             rst,
    window_avg_out_if.slave  bus
);
    localparam int              LG         = $clog2(DEPTH);
    localparam int              FW         = $clog2(FRAME);
    localparam logic [SW:0]     HALF       = (SW+1)'(DEPTH / 2);
    localparam logic [LG:0]     WARM_DONE  = (LG+1)'(DEPTH);
    localparam logic [LG:0]     WARM_ONE   = (LG+1)'(1);
    localparam logic [FW-1:0]   FRAME_LAST = FW'(FRAME - 1);
    localparam logic [FW-1:0]   FRAME_ONE  = FW'(1);

    logic [SW:0]      rnd;
    logic [WIDTH-1:0] avg;
    logic             pop, push;
    logic [WIDTH-1:0] new_min, new_max;

    logic [LG:0]      warm_q, warm_d;
    logic             s_valid_q, s_valid_d;
    logic [WIDTH-1:0] s_avg_q, s_avg_d;
    logic [WIDTH-1:0] q0_q, q0_d, q1_q, q1_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [FW-1:0]    fcnt_q, fcnt_d;
    logic [WIDTH-1:0] run_min_q, run_min_d, run_max_q, run_max_d;
    logic [WIDTH-1:0] min_q, min_d, max_q, max_d;
    logic             done_q, done_d;

    // Sum is widened by one bit so the rounding offset cannot wrap.
    assign rnd = {1'b0, bus.i_sum} + HALF;
    assign avg = WIDTH'(rnd >> LG);

    assign pop  = (cnt_q != 2'd0) && bus.i_ready;
    assign push = s_valid_q && ((cnt_q != 2'd2) || pop);

    assign new_min = (s_avg_q < run_min_q) ? s_avg_q : run_min_q;
    assign new_max = (s_avg_q > run_max_q) ? s_avg_q : run_max_q;

    always_comb begin
        warm_d    = warm_q;
        s_valid_d = 1'b0;
        s_avg_d   = s_avg_q;
        if (bus.i_valid) begin
            if (warm_q == WARM_DONE) begin
                s_valid_d = 1'b1;
                s_avg_d   = avg;
            end else begin
                warm_d = warm_q + WARM_ONE;
            end
        end
    end

    // q0 is always the head; a pop shifts q1 forward before any push lands.
    always_comb begin
        q0_d  = q0_q;
        q1_d  = q1_q;
        cnt_d = cnt_q;
        if (pop && push) begin
            if (cnt_q == 2'd1) begin
                q0_d = s_avg_q;
            end else begin
                q0_d = q1_q;
                q1_d = s_avg_q;
            end
        end else if (pop) begin
            q0_d  = q1_q;
            cnt_d = cnt_q - 2'd1;
        end else if (push) begin
            if (cnt_q == 2'd0) q0_d = s_avg_q;
            else               q1_d = s_avg_q;
            cnt_d = cnt_q + 2'd1;
        end
        ovf_d = ovf_q | (s_valid_q & ~push);
    end

    always_comb begin
        fcnt_d    = fcnt_q;
        run_min_d = run_min_q;
        run_max_d = run_max_q;
        min_d     = min_q;
        max_d     = max_q;
        done_d    = 1'b0;
        if (s_valid_q) begin
            if (fcnt_q == FRAME_LAST) begin
                min_d     = new_min;
                max_d     = new_max;
                done_d    = 1'b1;
                run_min_d = '1;
                run_max_d = '0;
                fcnt_d    = '0;
            end else begin
                run_min_d = new_min;
                run_max_d = new_max;
                fcnt_d    = fcnt_q + FRAME_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            warm_q    <= '0;
            s_valid_q <= 1'b0;
            s_avg_q   <= '0;
            q0_q      <= '0;
            q1_q      <= '0;
            cnt_q     <= 2'd0;
            ovf_q     <= 1'b0;
            fcnt_q    <= '0;
            run_min_q <= '1;
            run_max_q <= '0;
            min_q     <= '0;
            max_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            warm_q    <= warm_d;
            s_valid_q <= s_valid_d;
            s_avg_q   <= s_avg_d;
            q0_q      <= q0_d;
            q1_q      <= q1_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            fcnt_q    <= fcnt_d;
            run_min_q <= run_min_d;
            run_max_q <= run_max_d;
            min_q     <= min_d;
            max_q     <= max_d;
            done_q    <= done_d;
        end
    end

    assign bus.o_valid      = (cnt_q != 2'd0);
    assign bus.o_avg        = (cnt_q != 2'd0) ? q0_q : '0;
    assign bus.o_overflow   = ovf_q;
    assign bus.o_min        = min_q;
    assign bus.o_max        = max_q;
    assign bus.o_frame_done = done_q;
endmodule

// File: tb/tb_window_avg_out.sv
// tb/tb_window_avg_out.sv - directed scoreboard bench for window_avg_out
module tb_window_avg_out;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    window_avg_out_if #(.WIDTH(8), .SW(11)) bus ();

    window_avg_out #(.WIDTH(8), .DEPTH(8), .SW(11), .FRAME(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_assert = 0;
    int          n_fail   = 0;
    int          frames   = 0;
    logic [31:0] last_min = '0;
    logic [31:0] last_max = '0;
    logic [7:0]  sb[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Inputs change at the negedge; outputs are sampled there too, a half cycle from the active edge.
    task automatic tick(input logic [10:0] sum, input logic v, input logic rdy);
        logic [7:0] exp;
        bus.i_sum   = sum;
        bus.i_valid = v;
        bus.i_ready = rdy;
        if (bus.o_valid === 1'b1 && rdy) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 32'(sb.size()), 32'd1);
            end else begin
                exp = sb.pop_front();
                check("pop_avg", 32'(bus.o_avg), 32'(exp));
            end
        end
        @(negedge clk);
        if (bus.o_frame_done === 1'b1) begin
            frames++;
            last_min = 32'(bus.o_min);
            last_max = 32'(bus.o_max);
        end
    endtask

    task automatic check_zero_outs(input string tag);
        check({tag, "_valid"}, 32'(bus.o_valid), 32'd0);
        check({tag, "_avg"}, 32'(bus.o_avg), 32'd0);
        check({tag, "_ovf"}, 32'(bus.o_overflow), 32'd0);
        check({tag, "_min"}, 32'(bus.o_min), 32'd0);
        check({tag, "_max"}, 32'(bus.o_max), 32'd0);
        check({tag, "_done"}, 32'(bus.o_frame_done), 32'd0);
    endtask

    task automatic do_reset();
        bus.i_sum = '0; bus.i_valid = 1'b0; bus.i_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic warm_up(input logic [10:0] sum, input string tag);
        for (int i = 0; i < 8; i++) begin
            tick(sum, 1'b1, 1'b1);
            check(tag, 32'(bus.o_valid), 32'd0);
        end
    endtask

    initial begin
        logic [10:0] rsum[4];
        logic [7:0]  ravg[4];
        rsum[0] = 11'd11;   ravg[0] = 8'd1;
        rsum[1] = 11'd12;   ravg[1] = 8'd2;
        rsum[2] = 11'd2036; ravg[2] = 8'd255;
        rsum[3] = 11'd2039; ravg[3] = 8'd255;

        bus.i_sum = '0; bus.i_valid = 1'b0; bus.i_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_zero_outs("reset");
        rst = 1'b0;

        warm_up(11'd50, "warm_no_valid");
        tick(11'd100, 1'b1, 1'b1);
        sb.push_back(8'd13);
        check("latency_not_yet", 32'(bus.o_valid), 32'd0);
        tick(11'd0, 1'b0, 1'b0);
        check("latency_valid", 32'(bus.o_valid), 32'd1);
        check("latency_avg", 32'(bus.o_avg), 32'd13);
        repeat (2) tick(11'd0, 1'b0, 1'b1);

        for (int i = 0; i < 4; i++) begin
            sb.push_back(ravg[i]);
            tick(rsum[i], 1'b1, 1'b1);
        end
        repeat (3) tick(11'd0, 1'b0, 1'b1);
        check("round_drained", 32'(sb.size()), 32'd0);
        check("round_empty", 32'(bus.o_valid), 32'd0);

        sb.push_back(8'd10); tick(11'd80, 1'b1, 1'b0);
        sb.push_back(8'd20); tick(11'd160, 1'b1, 1'b0);
        tick(11'd240, 1'b1, 1'b0);
        repeat (2) tick(11'd0, 1'b0, 1'b0);
        check("bp_ovf_set", 32'(bus.o_overflow), 32'd1);
        check("bp_head", 32'(bus.o_avg), 32'd10);
        repeat (3) tick(11'd0, 1'b0, 1'b1);
        check("bp_drained", 32'(sb.size()), 32'd0);
        check("bp_empty", 32'(bus.o_valid), 32'd0);
        check("bp_ovf_sticky", 32'(bus.o_overflow), 32'd1);

        tick(11'd80, 1'b1, 1'b0);
        tick(11'd0, 1'b0, 1'b0);
        check("pre_rst_valid", 32'(bus.o_valid), 32'd1);
        #2 rst = 1'b1;
        #1 check_zero_outs("async_rst");
        @(negedge clk);
        rst = 1'b0;
        warm_up(11'd80, "rewarm_no_valid");

        sb.push_back(8'd10); tick(11'd80, 1'b1, 1'b0);
        sb.push_back(8'd20); tick(11'd160, 1'b1, 1'b0);
        sb.push_back(8'd30); tick(11'd240, 1'b1, 1'b0);
        tick(11'd0, 1'b0, 1'b1);
        check("full_pp_ovf", 32'(bus.o_overflow), 32'd0);
        check("full_pp_head", 32'(bus.o_avg), 32'd20);
        repeat (3) tick(11'd0, 1'b0, 1'b1);
        check("full_pp_drained", 32'(sb.size()), 32'd0);
        check("full_pp_empty", 32'(bus.o_valid), 32'd0);
        check("full_pp_ovf_end", 32'(bus.o_overflow), 32'd0);

        do_reset();
        frames = 0;
        warm_up(11'd0, "frame_warm");
        for (int a = 25; a >= 10; a--) begin
            sb.push_back(8'(a));
            tick(11'(a * 8), 1'b1, 1'b1);
        end
        repeat (2) tick(11'd0, 1'b0, 1'b1);
        check("frame1_count", 32'(frames), 32'd1);
        check("frame1_min", last_min, 32'd10);
        check("frame1_max", last_max, 32'd25);
        check("frame1_out_min", 32'(bus.o_min), 32'd10);
        check("frame1_out_max", 32'(bus.o_max), 32'd25);

        for (int i = 0; i < 16; i++) begin
            sb.push_back(8'd7);
            tick(11'd56, 1'b1, 1'b1);
            if (i == 14) check("frame2_not_early", 32'(frames), 32'd1);
        end
        repeat (2) tick(11'd0, 1'b0, 1'b1);
        check("frame2_count", 32'(frames), 32'd2);
        check("frame2_min", last_min, 32'd7);
        check("frame2_max", last_max, 32'd7);
        check("frame_done_low", 32'(bus.o_frame_done), 32'd0);
        check("final_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
